// File: rtl/datapath.sv
// rtl/datapath.sv - register-transfer datapath: shared 32-bit bus, MDR/IR/Y/R1-R3, AND ALU into 64-bit Z
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        AND,
  output logic [31:0] BusMuxOut,
  output logic [31:0] R1_data,
  output logic [31:0] R2_data,
  output logic [31:0] R3_data,
  output logic [31:0] IR_data,
  output logic [63:0] Z_data
);

  logic [31:0] pc, ir, mdr, y, r1, r2, r3;
  logic [63:0] z;
  logic [63:0] alu_result;

  always_comb begin
    BusMuxOut = 32'h0;
    if (MDRout)       BusMuxOut = mdr;
    else if (Zlowout) BusMuxOut = z[31:0];
    else if (PCout)   BusMuxOut = pc;
    else if (R2out)   BusMuxOut = r2;
    else if (R3out)   BusMuxOut = r3;
  end

  assign alu_result = {32'h0, y & BusMuxOut};

  // PC has no load path; it is held at its reset value.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) pc <= 32'h0;
    else        pc <= pc;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ir  <= 32'h0;
      mdr <= 32'h0;
      y   <= 32'h0;
      r1  <= 32'h0;
      r2  <= 32'h0;
      r3  <= 32'h0;
      z   <= 64'h0;
    end else begin
      if (MDRin) mdr <= Read ? Mdatain : BusMuxOut;
      if (IRin)  ir  <= BusMuxOut;
      if (Yin)   y   <= BusMuxOut;
      if (R1in)  r1  <= BusMuxOut;
      if (R2in)  r2  <= BusMuxOut;
      if (R3in)  r3  <= BusMuxOut;
      if (AND)   z   <= alu_result;
    end
  end

  assign R1_data = r1;
  assign R2_data = r2;
  assign R3_data = r3;
  assign IR_data = ir;
  assign Z_data  = z;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed scenarios plus randomized control words checked against a transfer-level model
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, MDRin, IRin, Yin, R1in, R2in, R3in;
  logic        PCout, Zlowout, MDRout, R2out, R3out, AND;
  logic [31:0] BusMuxOut, R1_data, R2_data, R3_data, IR_data;
  logic [63:0] Z_data;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .AND(AND), .BusMuxOut(BusMuxOut), .R1_data(R1_data), .R2_data(R2_data),
    .R3_data(R3_data), .IR_data(IR_data), .Z_data(Z_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what each register should hold.
  logic [31:0] m_mdr, m_ir, m_y, m_r1, m_r2, m_r3;
  logic [63:0] m_z;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_bus();
    if (MDRout)       return m_mdr;
    if (Zlowout)      return m_z[31:0];
    if (PCout)        return 32'h0;
    if (R2out)        return m_r2;
    if (R3out)        return m_r3;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_mdr = 0; m_ir = 0; m_y = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 0;
  endtask

  task automatic idle();
    Read = 0; MDRin = 0; IRin = 0; Yin = 0; R1in = 0; R2in = 0; R3in = 0;
    PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0; AND = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".r1"}, {32'h0, R1_data}, {32'h0, m_r1});
    check({tag, ".r2"}, {32'h0, R2_data}, {32'h0, m_r2});
    check({tag, ".r3"}, {32'h0, R3_data}, {32'h0, m_r3});
    check({tag, ".ir"}, {32'h0, IR_data}, {32'h0, m_ir});
    check({tag, ".z"},  Z_data, m_z);
  endtask

  // Apply the currently driven controls across one rising edge.
  task automatic tick(input string tag);
    logic [31:0] b;
    logic [31:0] y_old;
    #1;
    b = model_bus();
    check({tag, ".bus"}, {32'h0, BusMuxOut}, {32'h0, b});
    y_old = m_y;
    @(posedge clock);
    if (MDRin) m_mdr = Read ? Mdatain : b;
    if (IRin)  m_ir = b;
    if (Yin)   m_y  = b;
    if (R1in)  m_r1 = b;
    if (R2in)  m_r2 = b;
    if (R3in)  m_r3 = b;
    if (AND)   m_z  = {32'h0, y_old & b};
    #1;
    check_regs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #2 clear = 0;
    #1;
    model_reset();
    check({tag, ".bus"}, {32'h0, BusMuxOut}, 64'h0);
    check_regs(tag);
    clear = 1;
  endtask

  initial begin
    idle();
    Mdatain = 0;
    clear = 0;
    model_reset();
    #3;
    check_regs("reset");
    check("reset.bus", {32'h0, BusMuxOut}, 64'h0);
    @(negedge clock);
    clear = 1;
    @(posedge clock); #1;

    idle(); Read = 1; MDRin = 1; Mdatain = 32'h12; tick("init_mdr12");
    idle(); MDRout = 1; R2in = 1; Mdatain = 32'h11; tick("init_r2");
    check("init.r2_const", {32'h0, R2_data}, 64'h12);
    idle(); Read = 1; MDRin = 1; Mdatain = 32'h14; tick("init_mdr14");
    idle(); MDRout = 1; R3in = 1; Mdatain = 32'h13; tick("init_r3");
    check("init.r3_const", {32'h0, R3_data}, 64'h14);
    idle(); Read = 1; MDRin = 1; Mdatain = 32'h18; tick("init_mdr18");
    idle(); MDRout = 1; R1in = 1; Mdatain = 32'h17; tick("init_r1");
    check("init.r1_const", {32'h0, R1_data}, 64'h18);

    idle(); R2out = 1; Yin = 1; tick("and_y");
    idle(); R3out = 1; AND = 1; tick("and_z");
    check("and.z_const", Z_data, 64'h10);
    idle(); Zlowout = 1; R1in = 1; tick("and_r1");
    check("and.r1_const", {32'h0, R1_data}, 64'h10);

    idle(); Read = 1; MDRin = 1; Mdatain = 32'h3; tick("fetch_mdr");
    idle(); MDRout = 1; IRin = 1; tick("fetch_ir");
    check("fetch.ir_const", {32'h0, IR_data}, 64'h3);
    idle(); PCout = 1; #1;
    check("fetch.pc_bus", {32'h0, BusMuxOut}, 64'h0);

    idle(); R2out = 1; MDRin = 1; Read = 0; Mdatain = 32'hdead_beef; tick("mdr_bus");
    idle(); MDRout = 1; #1;
    check("mdr_bus.val", {32'h0, BusMuxOut}, 64'h12);
    idle(); #1;
    check("empty_bus", {32'h0, BusMuxOut}, 64'h0);

    idle(); MDRout = 1; R3out = 1; #1;
    check("priority", {32'h0, BusMuxOut}, 64'h12);

    // Asynchronous clear between edges, with a drive still asserted.
    idle(); @(posedge clock); #1;
    MDRout = 1; R1in = 1; AND = 1;
    reset_pulse("async_clr");
    idle(); Read = 1; MDRin = 1; Mdatain = 32'h55; tick("post_clr_mdr");
    idle(); MDRout = 1; R1in = 1; tick("post_clr_r1");
    check("post_clr.r1_const", {32'h0, R1_data}, 64'h55);

    for (int i = 0; i < 400; i++) begin
      {Read, MDRin, IRin, Yin, R1in, R2in, R3in} = 7'($urandom);
      {PCout, Zlowout, MDRout, R2out, R3out, AND} = 6'($urandom) & 6'($urandom);
      Mdatain = $urandom;
      if ($urandom_range(0, 24) == 0) reset_pulse("rnd_clr");
      else tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
